// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment scan driver: glyph table,
// blank pattern and the output polarity helper.
package sevenseg_pkg;

  localparam int SEG_W = 7;

  // Active-high blank pattern (all segments off).
  localparam logic [SEG_W-1:0] SEG_BLANK = '0;

  // Active-high hex glyphs, bit order {g,f,e,d,c,b,a}; entry 15 first.
  localparam logic [15:0][SEG_W-1:0] HEX_GLYPH = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Convert an active-high segment vector to the board polarity.
  function automatic logic [SEG_W-1:0] seg_polarity(input logic [SEG_W-1:0] seg,
                                                    input logic active_low);
    return active_low ? ~seg : seg;
  endfunction

endpackage

// File: rtl/hex_to_7seg_glyph.sv
// Combinational nibble -> active-high seven-segment glyph lookup.
module hex_to_7seg_glyph
  import sevenseg_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] glyph
);

  // Straight table lookup; polarity is handled by the caller.
  always_comb begin
    glyph = HEX_GLYPH[nibble];
  end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed N-digit seven-segment scan driver with leading-zero
// blanking, per-digit blink, decimal points and frame-synchronous input
// latching. Optional macro SEVENSEG_DIMMING_EN adds a brightness input that
// narrows the lit window inside each digit slot.
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS     = 6,
  parameter int SCAN_DIV       = 50000,
  parameter int BLINK_LOG2     = 24,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    blank_lz,
`ifdef SEVENSEG_DIMMING_EN
  input  logic [3:0]              brightness,
`endif
  output logic [SEG_W-1:0]        seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic ACT_LOW = (SEG_ACTIVE_LOW != 0);
  localparam logic [SEG_W-1:0] SEG_OFF = ACT_LOW ? '1 : '0;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = ACT_LOW ? '1 : '0;

  logic [PW-1:0]                  presc_q, presc_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic [BLINK_LOG2-1:0]          blink_q, blink_d;
  logic                           first_q, first_d;
  logic [NUM_DIGITS-1:0][3:0]     sh_dig_q, sh_dig_d;
  logic [NUM_DIGITS-1:0]          sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0]          sh_bm_q, sh_bm_d;
  logic [SEG_W-1:0]               seg_q, seg_d;
  logic                           dp_q, dp_d;
  logic [NUM_DIGITS-1:0]          an_q, an_d;
  logic                           fd_q, fd_d;
  logic                           wrap;

  // On the first cycle after reset the shadow is still zero, so the display
  // path looks through to the live inputs being latched that same cycle.
  logic [NUM_DIGITS-1:0][3:0]     cur_dig;
  logic [NUM_DIGITS-1:0]          cur_dp, cur_bm;
  logic [3:0]                     nib;
  logic [SEG_W-1:0]               glyph;

  assign cur_dig = first_q ? digits     : sh_dig_q;
  assign cur_dp  = first_q ? dp         : sh_dp_q;
  assign cur_bm  = first_q ? blink_mask : sh_bm_q;
  assign nib     = cur_dig[idx_q];

`ifdef SEVENSEG_DIMMING_EN
  logic [3:0] sh_bri_q, sh_bri_d, cur_bri;
  assign cur_bri = first_q ? brightness : sh_bri_q;
`endif

  hex_to_7seg_glyph u_glyph (.nibble(nib), .glyph(glyph));

  // Prescaler, digit index, blink counter and shadow latch.
  always_comb begin
    presc_d = presc_q;
    idx_d   = idx_q;
    wrap    = 1'b0;
    if (en) begin
      if (presc_q == PW'(SCAN_DIV - 1)) begin
        presc_d = '0;
        if (idx_q == IW'(NUM_DIGITS - 1)) begin
          idx_d = '0;
          wrap  = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
    blink_d  = blink_q + 1'b1;
    first_d  = 1'b0;
    fd_d     = wrap;
    sh_dig_d = (wrap || first_q) ? digits     : sh_dig_q;
    sh_dp_d  = (wrap || first_q) ? dp         : sh_dp_q;
    sh_bm_d  = (wrap || first_q) ? blink_mask : sh_bm_q;
`ifdef SEVENSEG_DIMMING_EN
    sh_bri_d = (wrap || first_q) ? brightness : sh_bri_q;
`endif
  end

  // Blanking, decode and polarity for the next registered output sample.
  logic [NUM_DIGITS-1:0]   lz_vec;
  logic                    all_zero, blanked, lit, dp_act;
  logic [SEG_W-1:0]        seg_act;
  logic [NUM_DIGITS-1:0]   an_act;
`ifdef SEVENSEG_DIMMING_EN
  logic [PW+36:0]          win_lim;
`endif
  always_comb begin
    lz_vec   = '0;
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero  = all_zero & (cur_dig[i] == 4'h0);
      lz_vec[i] = all_zero & (i != 0);
    end
    blanked = (blank_lz & lz_vec[idx_q]) | (blink_q[BLINK_LOG2-1] & cur_bm[idx_q]);
`ifdef SEVENSEG_DIMMING_EN
    win_lim = ((PW+37)'(cur_bri) + 1'b1) * (PW+37)'(SCAN_DIV) >> 4;
    lit     = (PW+37)'(presc_q) < win_lim;
`else
    lit     = 1'b1;
`endif
    seg_act        = blanked ? SEG_BLANK : glyph;
    dp_act         = cur_dp[idx_q] & ~blanked;
    an_act         = '0;
    an_act[idx_q]  = 1'b1;
    if (!(en && lit)) begin
      seg_act = SEG_BLANK;
      dp_act  = 1'b0;
      an_act  = '0;
    end
    seg_d = seg_polarity(seg_act, ACT_LOW);
    dp_d  = ACT_LOW ? ~dp_act : dp_act;
    an_d  = ACT_LOW ? ~an_act : an_act;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q  <= '0;
      idx_q    <= '0;
      blink_q  <= '0;
      first_q  <= 1'b1;
      sh_dig_q <= '0;
      sh_dp_q  <= '0;
      sh_bm_q  <= '0;
      seg_q    <= SEG_OFF;
      dp_q     <= ACT_LOW;
      an_q     <= AN_OFF;
      fd_q     <= 1'b0;
`ifdef SEVENSEG_DIMMING_EN
      sh_bri_q <= '0;
`endif
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      blink_q  <= blink_d;
      first_q  <= first_d;
      sh_dig_q <= sh_dig_d;
      sh_dp_q  <= sh_dp_d;
      sh_bm_q  <= sh_bm_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      an_q     <= an_d;
      fd_q     <= fd_d;
`ifdef SEVENSEG_DIMMING_EN
      sh_bri_q <= sh_bri_d;
`endif
    end
  end

  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign an_out     = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Scoreboard bench for sevenseg_scan_driver (4 digits, 4-cycle slots,
// 5-bit blink counter, active-low outputs). Stimulus pushes one expected
// output sample per clock; the monitor pops and compares on each falling edge.
module tb_sevenseg_scan_driver;

  localparam int ND = 4;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  // Hand-written active-low glyph sets, index = digit position.
  localparam logic [3:0][6:0] S1234   = {7'h79, 7'h24, 7'h30, 7'h19};
  localparam logic [3:0][6:0] SABCD   = {7'h08, 7'h03, 7'h46, 7'h21};
  localparam logic [3:0][6:0] S0050LZ = {7'h7F, 7'h7F, 7'h12, 7'h40};
  localparam logic [3:0][6:0] S0050   = {7'h40, 7'h40, 7'h12, 7'h40};

  logic            clk = 1'b0;
  logic            reset;
  logic            en;
  logic [4*ND-1:0] digits;
  logic [ND-1:0]   dp;
  logic [ND-1:0]   blink_mask;
  logic            blank_lz;
  logic [6:0]      seg_out;
  logic            dp_out;
  logic [ND-1:0]   an_out;
  logic            frame_done;

  exp_t q[$];
  exp_t e;
  int   vectors = 0;
  int   errs    = 0;
  int   kk      = 0;   // edges since the latest reset release

  sevenseg_scan_driver #(
    .NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_LOG2(5), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .digits(digits), .dp(dp),
    .blink_mask(blink_mask), .blank_lz(blank_lz), .seg_out(seg_out),
    .dp_out(dp_out), .an_out(an_out), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Monitor: one expected sample per falling edge while the queue holds any.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      e = q.pop_front();
      vectors++;
      if ({an_out, seg_out, dp_out, frame_done} !== e) begin
        errs++;
        $display("FAIL vec%0d t=%0t: got an=%b seg=%b dp=%b fd=%b, want an=%b seg=%b dp=%b fd=%b",
                 vectors, $time, an_out, seg_out, dp_out, frame_done, e.an, e.seg, e.dp, e.fd);
      end
    end
  end

  // All outputs inactive, no frame pulse.
  task automatic push_off(input logic step);
    exp_t x;
    x.an = 4'hF; x.seg = 7'h7F; x.dp = 1'b1; x.fd = 1'b0;
    q.push_back(x);
    if (step) kk++;
  endtask

  // Expected sample for frame position pos (digit pos/4), blink phase from kk.
  task automatic push_pos(input logic [3:0][6:0] segs, input logic [3:0] dpv,
                          input logic [3:0] bm, input int pos);
    exp_t x;
    int   d;
    logic blk;
    d   = pos / 4;
    blk = bm[d] && (((kk >> 4) & 1) == 1);
    x.an    = 4'hF;
    x.an[d] = 1'b0;
    x.seg   = blk ? 7'h7F : segs[d];
    x.dp    = blk ? 1'b1 : ~dpv[d];
    x.fd    = (pos == 15);
    q.push_back(x);
    kk++;
  endtask

  task automatic push_range(input logic [3:0][6:0] segs, input logic [3:0] dpv,
                            input logic [3:0] bm, input int from, input int to);
    for (int p = from; p <= to; p++) push_pos(segs, dpv, bm, p);
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; en = 1'b1; digits = 16'h1234; dp = '0; blink_mask = '0; blank_lz = 1'b0;
    push_off(1'b0);                       // reset state
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    kk = 0;
    push_off(1'b0);                       // still idle before first edge
    // Basic scan of 1234, two frames.
    push_range(S1234, 4'h0, 4'h0, 0, 15);
    push_range(S1234, 4'h0, 4'h0, 0, 15);
    run(32);
    // Inputs change mid-frame: current frame completes with old values.
    push_range(S1234, 4'h0, 4'h0, 0, 5);
    run(6);
    digits = 16'hABCD;
    push_range(S1234, 4'h0, 4'h0, 6, 15);
    push_range(SABCD, 4'h0, 4'h0, 0, 15);
    run(26);
    // Leading-zero blanking on, then off.
    digits = 16'h0050; blank_lz = 1'b1;
    push_range(SABCD, 4'h0, 4'h0, 0, 15);
    push_range(S0050LZ, 4'h0, 4'h0, 0, 15);
    run(32);
    blank_lz = 1'b0;
    push_range(S0050, 4'h0, 4'h0, 0, 15);
    run(16);
    // Blink and decimal point on digit 0; both blink phases covered.
    digits = 16'h1234; blink_mask = 4'b0001; dp = 4'b0001;
    push_range(S0050, 4'h0, 4'h0, 0, 15);
    push_range(S1234, 4'b0001, 4'b0001, 0, 15);
    push_range(S1234, 4'b0001, 4'b0001, 0, 15);
    run(48);
    // Disable mid-slot for 10 cycles, then resume the same slot.
    push_range(S1234, 4'b0001, 4'b0001, 0, 1);
    run(2);
    en = 1'b0;
    repeat (10) push_off(1'b1);
    run(10);
    en = 1'b1;
    push_range(S1234, 4'b0001, 4'b0001, 2, 15);
    run(14);
    // Asynchronous reset in the frame_done cycle.
    push_range(S1234, 4'b0001, 4'b0001, 0, 14);
    run(15);
    @(posedge clk);
    #2;
    reset = 1'b0;
    push_off(1'b0);
    push_off(1'b0);
    push_off(1'b0);
    run(2);
    reset = 1'b1;
    kk = 0;
    push_range(S1234, 4'b0001, 4'b0001, 0, 7);
    run(8);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL drain: %0d samples left unchecked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_driver.md
Name: sevenseg_scan_driver

Overview:
- Parametrised, time-multiplexed N-digit seven-segment driver; successor to the static per-digit decoder bank.
- Scans one digit per slot through shared segment lines plus one-hot anode enables.
- Adds leading-zero blanking, per-digit blink, decimal points and frame-synchronous input latching.
- Sits between the BCD clock / TLC timer datapath and board display pins.

Parameters:
- NUM_DIGITS, 6, number of digits scanned (2..8); digit NUM_DIGITS-1 is most significant.
- SCAN_DIV, 50000, clk cycles per digit slot (>=2).
- BLINK_LOG2, 24, width of the free-running blink counter; the counter MSB is the blink phase.
- SEG_ACTIVE_LOW, 1, when 1 the segment, dp and anode outputs are active-low.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- en  in  1  scan enable
- digits  in  4*NUM_DIGITS  hex nibbles; digit i = digits[4i+3:4i]
- dp  in  NUM_DIGITS  decimal point request per digit
- blink_mask  in  NUM_DIGITS  digit blinks when set
- blank_lz  in  1  leading-zero blanking enable
- seg_out  out  7  segments {g,f,e,d,c,b,a}, registered
- dp_out  out  1  decimal point, registered
- an_out  out  NUM_DIGITS  one-hot digit enable, registered
- frame_done  out  1  one-cycle pulse at the end of each full scan

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - Prescaler = 0, digit index = 0, blink counter = 0, shadow registers = 0.
  - seg_out, dp_out and an_out are driven at their inactive level (all 1 if SEG_ACTIVE_LOW, else all 0).
  - frame_done = 0.
- Prescaler:
  - Counts 0..SCAN_DIV-1 while en = 1.
  - At the terminal count it wraps to 0 and the index advances to (idx+1) mod NUM_DIGITS.
- Shadow latch: digits, dp and blink_mask are captured into shadow registers when the index wraps NUM_DIGITS-1 -> 0, and on the first cycle after reset release. Within a frame only shadow values are displayed, so there is no tearing.
- frame_done pulses for exactly one cycle, the same cycle the shadow latch occurs, except after reset.
- Output pipeline: one register stage. an_out, seg_out and dp_out reflect the index and shadow values of the previous cycle. All three change together, so there are no ghosting cycles.
- Decode: nibble 0-F maps to standard hex glyphs (0-9, A, b, C, d, E, F).
- Leading-zero blanking: with blank_lz = 1, digit i (i >= 1) is blanked if shadow digits i..NUM_DIGITS-1 are all 0. Digit 0 is never blanked by this rule.
- Blink: blink counter free-runs whenever not in reset, independent of en. When the blink phase is 1 and shadow blink_mask[i] = 1, digit i is blanked.
- Blanking effect:
  - Segments and dp go inactive.
  - The anode stays active, so slot timing is uniform.
- Priority: blink and leading-zero blanking are OR-combined. dp is suppressed whenever its digit is blanked.
- en = 0:
  - Prescaler and index hold.
  - Outputs go inactive on the next cycle.
  - No frame_done pulses.
  - On re-enable, scanning resumes from the held index.
- en toggles mid-slot: the remaining slot count is preserved.
- Reset mid-frame: immediate return to the reset state; the next frame starts at digit 0 with fresh latched inputs.

Optional Feature:
- Macro: SEVENSEG_DIMMING_EN.
- Defined:
  - Adds input brightness [3:0].
  - Within each slot, the anode is active only while prescaler < ((brightness+1) * SCAN_DIV) / 16, computed with full-width multiply then shift; outside that window outputs are inactive.
  - brightness is latched with the shadow registers.
  - brightness = 15 is identical to full on.
- Undefined: the port is absent and the anode is active for the whole slot.

Decomposition:
- Package sevenseg_pkg:
  - SEG_W = 7.
  - 16-entry hex glyph constant table (active-high form).
  - SEG_BLANK constant.
  - Function applying the SEG_ACTIVE_LOW inversion.
- Sub-module hex_to_7seg_glyph: combinational nibble -> 7-bit active-high glyph. It is instantiated once on the muxed digit. The top owns the counters, shadow latch, blanking and polarity.

Test Plan (NUM_DIGITS = 4, SCAN_DIV = 4, BLINK_LOG2 = 5, SEG_ACTIVE_LOW = 1):
- Reset release, en = 1, digits = 16'h1234 -> an_out cycles 1110, 1101, 1011, 0111 at 4 cycles each. seg_out shows 4 (0011001), 3, 2, 1 in step with the anodes. frame_done pulses every 16 cycles.
- digits = 16'h0050, blank_lz = 1 -> digits 3 and 2 show 1111111. Digit 1 shows 5 and digit 0 shows 0 (1000000). With blank_lz = 0, digit 3 shows 0.
- Change digits from 16'h1234 to 16'hABCD mid-frame -> the current frame completes with 1234. The next frame, starting at the frame_done cycle, shows d, C, b, A.
- blink_mask = 4'b0001, dp = 4'b0001 -> digit 0 segments and dp are inactive while the blink counter MSB = 1 (16 of every 32 cycles); other digits are unaffected.
- Deassert en mid-slot for 10 cycles -> outputs are all 1 the next cycle and the index holds. On re-enable, the same digit completes its remaining slot cycles.
- Assert reset mid-frame -> outputs are inactive and frame_done = 0 immediately (asynchronous). After release, the scan restarts at digit 0 (an_out = 1110).
